aes_round_tail_stage: RTL
=========================

Name: aes_round_tail_stage

Overview:
- Registered stage directly downstream of the 128-bit SubBytes block.
- Takes the SubBytes output plus the round key and applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey.
- Uses a valid/ready handshake so the iterative AES round loop or an unrolled pipeline can stall without dropping a state.
- Its output feeds the next round's SubBytes input or the ciphertext port.

Parameters:
- TAG_W, 4, width of the side-band tag (typically the round number) carried alongside the state.
- SKID_BUF, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream state/key valid.
- in_ready  output  1  stage can accept this cycle.
- in_state  input  128  SubBytes output.
- in_key  input  128  round key.
- in_last  input  1  final round: bypass MixColumns.
- in_tag  input  TAG_W  side-band, passed through unchanged.
- out_valid  output  1  output state valid.
- out_ready  input  1  downstream accepts.
- out_state  output  128  ShiftRows→[MixColumns]→XOR key.
- out_last  output  1  registered copy of in_last.
- out_tag  output  TAG_W  registered copy of in_tag.

Behaviour:
- Byte layout:
  - Byte k (0..15) is bits [127-8k -: 8].
  - Row r = k%4, column c = k/4 (FIPS-197 column-major, byte 0 in the MSBs).
- ShiftRows: out byte (r,c) = in byte (r,(c+r)%4).
- MixColumns:
  - Per column, GF(2^8) with polynomial 0x11B, coefficient rows {02 03 01 01} rotated.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0), truncated to 8 bits.
- AddRoundKey: bitwise XOR of the full 128 bits with in_key.
- All datapath logic is combinational on the input side and captured into the output register. Latency is 1 cycle from an accepted input to out_valid.
- Transfer rules:
  - A transfer occurs on a rising edge where valid && ready.
  - out_state, out_last and out_tag are held stable while out_valid=1 and out_ready=0.
  - out_valid never deasserts without a completed transfer.
- SKID_BUF=0:
  - in_ready = !out_valid || out_ready.
  - Full throughput is one state per cycle.
- SKID_BUF=1:
  - Entries are the main output register and the skid register. in_ready = !skid_valid, registered.
  - Input accepted while main is full and out_ready=0 goes to skid.
  - On the next output transfer, skid moves to main.
  - Simultaneous input accept and output transfer with skid empty: main reloads directly.
  - Ordering is strictly FIFO; no state is lost or duplicated.
- Reset (asynchronous, any cycle including mid-transfer):
  - out_valid=0, skid_valid=0, out_state=0, out_last=0, out_tag=0.
  - in_ready=1 from the first cycle after rst_n rises.
  - Any in-flight state is discarded.
- in_valid with in_ready=0: no capture; upstream holds its data.
- in_last=1: out_state = ShiftRows(in_state) ^ in_key exactly.

Optional Feature:
- Macro: AES_ROUND_TAIL_PIPE2_EN.
- Defined:
  - Adds a second pipeline register between MixColumns and AddRoundKey; in_key is registered alongside the state.
  - Latency is 2 cycles.
  - Backpressure propagates through both stages with no bubble at sustained throughput. Each stage stalls only when its successor is full and not draining.
  - Reset clears both stages' valids.
- Undefined: single-stage behaviour as above, latency 1.

Test Plan:
- Round 1 (FIPS-197 App. B): in_state=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605, in_last=0 -> out_state=a49c7ff2689f352b6b5bea43026a5049 one cycle later (two with PIPE2), with out_tag equal to in_tag.
- Final round: in_state=e9098972cb31075f3d327d94af2e2cb5, in_key=d014f9a8c9ee2589e13f0cc8b6630ca6, in_last=1 -> out_state=3925841d02dc09fbdc118597196a0b32, out_last=1.
- Backpressure: 4 back-to-back inputs with tags 1..4 and out_ready=0 for 3 cycles -> SKID_BUF=1 holds two entries and in_ready drops to 0. After out_ready=1, outputs appear in order 1,2,3,4, one per cycle, with data stable during the stall.
- Throughput: in_valid=1 and out_ready=1 continuously for 16 states -> 16 outputs on 16 consecutive cycles after the initial latency, in_ready held at 1.
- Reset mid-operation: assert rst_n=0 asynchronously with main and skid full -> out_valid=0 and out_state=0 immediately. After release no stale state is emitted, and a new input produces the correct result.
- Zero/identity: in_state=0, in_key=0 -> out_state=0. in_state=0, in_key=ffff...ff -> out_state=ffff...ff.

Source files
------------

// File: rtl/aes_round_tail_stage.sv
// aes_round_tail_stage
//   Registered AES round tail that follows SubBytes. It applies ShiftRows,
//   then MixColumns (skipped on the final round), then AddRoundKey. The
//   result sits behind a valid/ready output register. When SKID_BUF=1 a
//   second skid entry is added, so in_ready is driven only by registers.
//   Optional build macro AES_ROUND_TAIL_PIPE2_EN adds a register stage
//   between MixColumns and AddRoundKey. The round key is carried through
//   that stage, and latency becomes 2.
//   Byte k of a 128-bit state occupies bits [127-8k -: 8]. The byte's row
//   is k%4 and its column is k/4.
`timescale 1ns/1ps
module aes_round_tail_stage #(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned SKID_BUF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_state,
  input  logic [127:0]     in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_state,
  output logic             out_last,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // out byte (r,c) = in byte (r,(c+r)%4)
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = s[127-8*(4*(((k/4)+(k%4))%4)+(k%4)) -: 8];
    end
    return o;
  endfunction

  // One column; a0 is row 0, which is the most significant byte
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  logic [127:0]     sr_d;
  logic [127:0]     mixed_d;

  // Feed into the output entries (directly from the input or from stage A)
  logic             b_valid;
  logic             b_ready;
  logic [127:0]     b_state;
  logic             b_last;
  logic [TAG_W-1:0] b_tag;

  logic             skid_valid;
  logic [127:0]     skid_state;
  logic             skid_last;
  logic [TAG_W-1:0] skid_tag;

  // ShiftRows, then MixColumns unless this is the final round
  always_comb begin
    sr_d    = shift_rows(in_state);
    mixed_d = in_last ? sr_d : mix_columns(sr_d);
  end

  // Output side can take a new state when skid is free, or the main register is free or draining
  always_comb begin
    if (SKID_BUF != 0) b_ready = !skid_valid;
    else               b_ready = !out_valid || out_ready;
  end

`ifdef AES_ROUND_TAIL_PIPE2_EN
  logic             a_valid;
  logic [127:0]     a_mixed;
  logic [127:0]     a_key;
  logic             a_last;
  logic [TAG_W-1:0] a_tag;
  logic             a_ready;

  // Stage A accepts when empty or when it hands its content on this cycle
  always_comb begin
    a_ready  = !a_valid || b_ready;
    in_ready = a_ready;
    b_valid  = a_valid;
    b_state  = a_mixed ^ a_key;
    b_last   = a_last;
    b_tag    = a_tag;
  end

  // Stage A register: post-MixColumns state with its round key alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_mixed <= '0;
      a_key   <= '0;
      a_last  <= 1'b0;
      a_tag   <= '0;
    end else if (a_ready) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_mixed <= mixed_d;
        a_key   <= in_key;
        a_last  <= in_last;
        a_tag   <= in_tag;
      end
    end
  end
`else
  // Single stage: AddRoundKey is applied directly on the input side
  always_comb begin
    in_ready = b_ready;
    b_valid  = in_valid;
    b_state  = mixed_d ^ in_key;
    b_last   = in_last;
    b_tag    = in_tag;
  end
`endif

  // Main output register plus skid entry. Skid only fills when SKID_BUF=1,
  // because otherwise b_ready already requires main to be free or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_state  <= '0;
      out_last   <= 1'b0;
      out_tag    <= '0;
      skid_valid <= 1'b0;
      skid_state <= '0;
      skid_last  <= 1'b0;
      skid_tag   <= '0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_state  <= skid_state;
        out_last   <= skid_last;
        out_tag    <= skid_tag;
        skid_valid <= 1'b0;
      end
    end else if (b_valid && b_ready) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_state <= b_state;
        out_last  <= b_last;
        out_tag   <= b_tag;
      end else begin
        skid_valid <= 1'b1;
        skid_state <= b_state;
        skid_last  <= b_last;
        skid_tag   <= b_tag;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
